uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Transmit-side buffer that sits directly upstream of the uart block. It accepts bytes from a host write port into a circular FIFO and drains them one at a time into the uart through the uart's datatx/start/ready handshake. Host writes are decoupled from the uart's serial rate of 10 clocks per bit, about 100 clocks per frame.

Parameters:
DATA_WIDTH, 8, width of each byte; matches the uart's DATA_WIDTH.
DEPTH, 16, number of FIFO entries; must be a power of two and at least 2.
ADDR_WIDTH, 4, log2(DEPTH); pointer width.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous reset, active-high.
wr_data  input  DATA_WIDTH  byte to enqueue.
wr_en  input  1  enqueue strobe, sampled each rising edge.
full  output  1  high when count == DEPTH.
empty  output  1  high when count == 0.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  one-cycle pulse when a write is rejected because the FIFO is full.
datatx  output  DATA_WIDTH  byte presented to the uart.
start  output  1  one-cycle launch pulse to the uart.
ready  input  1  uart transmitter idle flag.
busy  output  1  high while a byte is in flight (FSM not in IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; the reset port is named reset.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, overflow=0, start=0, datatx=0, busy=0, FSM=IDLE.
- Reset applied mid-transmission:
  - FIFO contents are discarded and start is forced low.
  - The uart frame already on the line is not aborted by this block.
  - After reset the FSM waits in IDLE for ready=1 before launching again.
- Write:
  - With wr_en=1 and full=0: store wr_data at wr_ptr, increment wr_ptr modulo DEPTH, count+1.
  - With wr_en=1 and full=1: data is dropped, state is unchanged, and overflow pulses for the next cycle.
- Pop: occurs only on the IDLE-to-LAUNCH transition. It reads the entry at rd_ptr into datatx, increments rd_ptr modulo DEPTH, count-1.
- Simultaneous write and pop in one cycle: count is unchanged and both pointers advance.
  - A write while full is rejected even if a pop happens in the same cycle; there is no fall-through.
- Pointers wrap naturally at DEPTH. full and empty are derived from count, never from pointer equality.
- FSM states:
  - IDLE: if empty=0 and ready=1, pop, register start=1 and datatx=head, then go to LAUNCH.
  - LAUNCH: start=0. If ready=0, go to WAIT_DONE; otherwise go to WAIT_BUSY.
  - WAIT_BUSY: wait for ready=0, then go to WAIT_DONE. There is no timeout.
  - WAIT_DONE: wait for ready=1, then go to IDLE.
- start is high for exactly one cycle per popped byte.
- datatx is held stable from the start pulse until the FSM returns to IDLE.
- Latency: with wr_en during cycle 0 into an empty FIFO and ready=1, empty deasserts after edge 1 and start is high during cycle 2.
- Back-to-back frames: the next start occurs no earlier than one cycle after the FSM returns to IDLE.
- With ready held low, nothing launches; the FIFO fills and then overflows per the write rules.
- busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg:
  - DATA_WIDTH default.
  - FSM state encoding (IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, 2 bits).
  - CLKS_PER_BIT=10 for benches.
- One sub-module: sync_fifo.
  - Storage, pointers, count, full, empty, overflow.
  - Write port and a pop strobe with registered read data.
- uart_tx_fifo instantiates sync_fifo and contains the launch FSM.

Test Plan:
1. Single byte: reset, write 0xED, uart idle -> start high in cycle 2 with datatx=0xED; tx serialises 0xED LSB-first; count returns to 0; busy falls once ready rises.
2. Burst ordering: write 0x55, 0xA5, 0x0F on consecutive cycles -> three start pulses, each only after ready has dropped and risen again; datatx sequence is 0x55, 0xA5, 0x0F; no byte is lost or duplicated.
3. Full/overflow: hold ready=0 and write 17 bytes 0x00..0x10 -> full=1 at count=16; overflow pulses once on the 17th write; releasing ready transmits 0x00..0x0F only.
4. Wrap-around: write and drain 40 bytes in mixed bursts -> output order matches input order across pointer wrap; count never exceeds 16.
5. Simultaneous write/pop: write 0x3C in the same cycle the FSM pops 0x11 with count=1 -> count stays 1; the next byte launched is 0x3C.
6. Reset mid-frame: load 4 bytes, assert reset for 1 cycle during the first frame -> all outputs return to reset values; no further start until new writes arrive and ready=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart transmit path: default byte width,
// launch FSM state encoding and the bit period used by benches.
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CLKS_PER_BIT   = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txState_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port and uart handshake of the transmit buffer, bundled so the
// buffer and its environment connect through a single port.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 4
);

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] datatx;
  logic                  start;
  logic                  ready;
  logic                  busy;

  modport master (
    output wr_data, wr_en, ready,
    input  full, empty, count, overflow, datatx, start, busy
  );

  modport slave (
    input  wr_data, wr_en, ready,
    output full, empty, count, overflow, datatx, start, busy
  );

endinterface

// File: rtl/sync_fifo.sv
// Circular byte FIFO with a pop strobe and registered read data; full and
// empty come from the occupancy count rather than from pointer comparison.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rdData_q, rdData_d;
  logic                  overflow_q, overflow_d;
  logic                  wrOk;
  logic                  popOk;

  assign full_o     = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign rd_data_o  = rdData_q;
  assign overflow_o = overflow_q;

  // A write while full is refused even when a pop frees a slot this cycle.
  assign wrOk  = wr_en_i && !full_o;
  assign popOk = pop_i && !empty_o;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    rdData_d   = rdData_q;
    overflow_d = wr_en_i && full_o;
    if (wrOk) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (popOk) begin
      rdPtr_d  = rdPtr_q + 1'b1;
      rdData_d = mem_q[rdPtr_q];
    end
    case ({wrOk, popOk})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      rdData_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      rdData_q   <= rdData_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wrOk) begin
      mem_q[wrPtr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer in front of the uart: queues host bytes and launches them
// one at a time through the uart's start/ready handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);

  txState_e state_q, state_d;
  logic     start_q, start_d;
  logic     pop;

  // The popped byte lands in the FIFO read register, which only changes on
  // the next pop and so stays stable for the whole frame.
  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_data_i  (bus.wr_data),
    .wr_en_i    (bus.wr_en),
    .pop_i      (pop),
    .rd_data_o  (bus.datatx),
    .full_o     (bus.full),
    .empty_o    (bus.empty),
    .count_o    (bus.count),
    .overflow_o (bus.overflow)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.empty && bus.ready) begin
          pop     = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH:    state_d = bus.ready ? WAIT_BUSY : WAIT_DONE;
      WAIT_BUSY: if (!bus.ready) state_d = WAIT_DONE;
      WAIT_DONE: if (bus.ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    start_d = pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
    end
  end

  assign bus.start = start_q;
  assign bus.busy  = (state_q != IDLE);

endmodule
